// File: rtl/async_operator_buf.sv
// Dataflow operator node: joins one token per input channel, applies the selected
// op, queues the result and hands every queued result to each consumer exactly once.
module async_operator_buf #(
  parameter int    data_width  = 32,
  parameter string op          = "add",
  parameter int    immediate   = 0,
  parameter int    input_size  = 2,
  parameter int    output_size = 1,
  parameter int    depth       = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  output logic [input_size-1:0]              req_l,
  input  logic [input_size-1:0]              ack_l,
  input  logic [data_width*input_size-1:0]   din,
  input  logic [output_size-1:0]             req_r,
  output logic [output_size-1:0]             ack_r,
  output logic [data_width-1:0]              dout,
  output logic [31:0]                        count,
  output logic [$clog2(depth):0]             occupancy
);

  localparam int AW = $clog2(depth);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0]         DEPTH_V = OW'(depth);
  localparam logic [data_width-1:0] IMM     = data_width'(immediate);

  // All arithmetic wraps modulo 2^data_width; d0 is the lowest operand slice.
  function automatic logic [data_width-1:0] apply_op(
    input logic [data_width*input_size-1:0] v
  );
    logic [data_width-1:0] acc;
    logic [data_width-1:0] d;
    acc = v[data_width-1:0];
    for (int k = 1; k < input_size; k++) begin
      d = v[k*data_width +: data_width];
      if (op == "add")      acc = acc + d;
      else if (op == "sub") acc = acc - d;
      else if (op == "mul") acc = acc * d;
    end
    if (op == "addi")      acc = acc + IMM;
    else if (op == "subi") acc = acc - IMM;
    else if (op == "muli") acc = acc * IMM;
    return acc;
  endfunction

  logic [input_size-1:0]            r_has;
  logic [input_size-1:0]            r_req_l;
  logic [data_width*input_size-1:0] r_opnd;
  logic [data_width-1:0]            r_mem [depth];
  logic [AW-1:0]                    r_wr_ptr;
  logic [AW-1:0]                    r_rd_ptr;
  logic [OW-1:0]                    r_occ;
  logic [31:0]                      r_count;
  logic [output_size-1:0]           r_sent;
  logic [output_size-1:0]           r_ack_r;
  logic [data_width-1:0]            r_dout;

  logic [input_size-1:0]            w_accept;
  logic [output_size-1:0]           w_issue;
  logic                             w_push;
  logic                             w_pop;
  logic [data_width-1:0]            w_result;
  logic [data_width-1:0]            w_head;

  assign w_accept = ack_l & ~r_has;
  assign w_push   = (&r_has) && (r_occ < DEPTH_V);
  assign w_result = apply_op(r_opnd);
  assign w_head   = r_mem[r_rd_ptr];
  assign w_issue  = {output_size{r_occ != '0}} & req_r & ~r_sent & ~r_ack_r;
  // The head leaves once every consumer has been (or is now being) acknowledged.
  assign w_pop    = (r_occ != '0) && (&(r_sent | w_issue));

  // Control state: input handshakes, FIFO bookkeeping and per-consumer delivery.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_has    <= '0;
      r_req_l  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_count  <= '0;
      r_sent   <= '0;
      r_ack_r  <= '0;
      r_dout   <= '0;
    end else begin
      r_req_l <= ~r_has & ~ack_l;
      r_has   <= w_push ? '0 : (r_has | w_accept);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_count  <= r_count + 32'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
      r_ack_r <= w_issue;
      r_sent  <= w_pop ? '0 : (r_sent | w_issue);
      if (|w_issue) r_dout <= w_head;
    end
  end

  // Datapath storage: operand latches and result memory carry no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < input_size; i++) begin
      if (w_accept[i]) r_opnd[i*data_width +: data_width] <= din[i*data_width +: data_width];
    end
    if (w_push) r_mem[r_wr_ptr] <= w_result;
  end

  assign req_l     = r_req_l;
  assign ack_r     = r_ack_r;
  assign dout      = r_dout;
  assign count     = r_count;
  assign occupancy = r_occ;

endmodule

// File: tb/tb_async_operator_buf.sv
// Bench for async_operator_buf: a queue-based reference model checks every ack
// of the 2-input add node, plus directed sub and muli nodes.
module tb_async_operator_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [1:0]  req_l0, ack_l0;
  logic [63:0] din0;
  logic [2:0]  req_r0, ack_r0;
  logic [31:0] dout0, count0;
  logic [2:0]  occ0;

  logic [2:0]  req_l1, ack_l1;
  logic [23:0] din1;
  logic [0:0]  req_r1, ack_r1;
  logic [7:0]  dout1;
  logic [31:0] count1;
  logic [1:0]  occ1;

  logic [0:0]  req_l2, ack_l2;
  logic [7:0]  din2;
  logic [0:0]  req_r2, ack_r2;
  logic [7:0]  dout2;
  logic [31:0] count2;
  logic [1:0]  occ2;

  async_operator_buf #(.data_width(32), .op("add"), .input_size(2), .output_size(3), .depth(4)) u0 (
    .clk(clk), .rst(rst), .req_l(req_l0), .ack_l(ack_l0), .din(din0), .req_r(req_r0),
    .ack_r(ack_r0), .dout(dout0), .count(count0), .occupancy(occ0));
  async_operator_buf #(.data_width(8), .op("sub"), .input_size(3), .output_size(1), .depth(2)) u1 (
    .clk(clk), .rst(rst), .req_l(req_l1), .ack_l(ack_l1), .din(din1), .req_r(req_r1),
    .ack_r(ack_r1), .dout(dout1), .count(count1), .occupancy(occ1));
  async_operator_buf #(.data_width(8), .op("muli"), .immediate(3), .input_size(1), .output_size(1), .depth(2)) u2 (
    .clk(clk), .rst(rst), .req_l(req_l2), .ack_l(ack_l2), .din(din2), .req_r(req_r2),
    .ack_r(ack_r2), .dout(dout2), .count(count2), .occupancy(occ2));

  int n_checks;
  int n_errors;
  logic [31:0] ch0[$], ch1[$], pend0[$], pend1[$], log0[$];
  int got[3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the n-th result is the sum of the n-th token of each channel;
  // every consumer must see the results in that order, each exactly once.
  task automatic monitor();
    int prev;
    logic [31:0] e;
    prev = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int j = 0; j < 3; j++) got[j] = 0;
        log0.delete();
        prev = 0;
      end else begin
        for (int j = 0; j < 3; j++) begin
          if (ack_r0[j]) begin
            if (got[j] >= ch0.size() || got[j] >= ch1.size()) begin
              n_checks++;
              n_errors++;
              $display("FAIL ack_extra out%0d: got ack with dout %0h, required no ack", j, dout0);
            end else begin
              e = ch0[got[j]] + ch1[got[j]];
              check($sformatf("dout0_out%0d_n%0d", j, got[j]), dout0, e);
            end
            if (j == 0) log0.push_back(dout0);
            got[j]++;
          end
        end
        check("occ0_step", (occ0 <= 3'd4) && (int'(occ0) - prev <= 1) && (prev - int'(occ0) <= 1), 1);
        prev = int'(occ0);
      end
    end
  endtask

  task automatic drive(input bit rnd, input logic [2:0] mask, input bit drain, input int max_cyc);
    int cyc;
    bit done;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      ack_l0 = '0;
      if (req_l0[0] && pend0.size() > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
        din0[31:0] = pend0.pop_front();
        ch0.push_back(din0[31:0]);
        ack_l0[0] = 1'b1;
      end
      if (req_l0[1] && pend1.size() > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
        din0[63:32] = pend1.pop_front();
        ch1.push_back(din0[63:32]);
        ack_l0[1] = 1'b1;
      end
      for (int j = 0; j < 3; j++) req_r0[j] = mask[j] && (!rnd || $urandom_range(0, 3) != 0);
      if (drain)
        done = pend0.size() == 0 && pend1.size() == 0 && got[0] == ch0.size() &&
               got[1] == ch0.size() && got[2] == ch0.size() && occ0 == 3'd0;
    end
    @(negedge clk);
    ack_l0 = '0;
    if (drain && !done) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: got %0d results pending, required 0", ch0.size() - got[2]);
    end
  endtask

  task automatic run_u1(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] e);
    int t;
    t = 0;
    while (req_l1 != 3'b111 && t < 20) begin @(negedge clk); t++; end
    din1 = {c, b, a};
    ack_l1 = 3'b111;
    @(negedge clk);
    ack_l1 = '0;
    t = 0;
    while (!ack_r1[0] && t < 20) begin @(negedge clk); t++; end
    check("u1_ack_seen", ack_r1, 1);
    check("u1_dout", dout1, e);
  endtask

  task automatic run_u2(input logic [7:0] a, input logic [7:0] e);
    int t;
    t = 0;
    while (!req_l2[0] && t < 20) begin @(negedge clk); t++; end
    din2 = a;
    ack_l2 = 1'b1;
    @(negedge clk);
    ack_l2 = '0;
    t = 0;
    while (!ack_r2[0] && t < 20) begin @(negedge clk); t++; end
    check("u2_ack_seen", ack_r2, 1);
    check("u2_dout", dout2, e);
  endtask

  initial begin
    logic [7:0] a, b, c, e8;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    ack_l0 = '0; din0 = '0; req_r0 = '0;
    ack_l1 = '0; din1 = '0; req_r1 = 1'b1;
    ack_l2 = '0; din2 = '0; req_r2 = 1'b1;
    fork monitor(); join_none
    #1;
    check("rst_req_l", req_l0, 0);
    check("rst_ack_r", ack_r0, 0);
    check("rst_count", count0, 0);
    check("rst_occ", occ0, 0);
    check("rst_dout", dout0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Two directed sums, all consumers requesting.
    pend0.push_back(32'd3);  pend1.push_back(32'd4);
    pend0.push_back(32'd10); pend1.push_back(32'd20);
    drive(1'b0, 3'b111, 1'b1, 200);
    check("add_first", log0.size() > 0 ? log0[0] : 32'hDEAD_BEEF, 32'd7);
    check("add_second", log0.size() > 1 ? log0[1] : 32'hDEAD_BEEF, 32'd30);
    check("add_count", count0, 2);
    check("add_occ", occ0, 0);

    // Random tokens and consumer stalls, including a wrapping sum.
    pend0.push_back(32'hFFFF_FFFF); pend1.push_back(32'd1);
    for (int k = 0; k < 39; k++) begin
      pend0.push_back($urandom);
      pend1.push_back($urandom);
    end
    drive(1'b1, 3'b111, 1'b1, 3000);
    check("rand_count", count0, 42);
    check("rand_occ", occ0, 0);

    // Slow consumer 2: FIFO fills, upstream stalls, spurious acks ignored.
    for (int k = 1; k <= 6; k++) begin
      pend0.push_back(32'(k));
      pend1.push_back(32'd0);
    end
    drive(1'b0, 3'b011, 1'b0, 40);
    check("full_got0", got[0], 43);
    check("full_got1", got[1], 43);
    check("full_got2", got[2], 42);
    check("full_occ", occ0, 4);
    check("full_req_l", req_l0, 0);
    check("full_count", count0, 46);
    @(negedge clk);
    ack_l0 = 2'b11;
    din0 = {32'h55, 32'h77};
    @(negedge clk);
    ack_l0 = '0;
    repeat (3) @(negedge clk);
    check("spur_occ", occ0, 4);
    check("spur_count", count0, 46);
    drive(1'b0, 3'b111, 1'b1, 400);
    check("release_count", count0, 48);
    check("release_got2", got[2], 48);

    // Asynchronous reset mid-stream with entries queued and an ack high.
    for (int k = 0; k < 3; k++) begin
      pend0.push_back($urandom);
      pend1.push_back($urandom);
    end
    drive(1'b0, 3'b000, 1'b0, 30);
    check("pre_rst_occ", occ0, 3);
    req_r0 = 3'b001;
    @(negedge clk);
    check("pre_rst_ack", ack_r0, 3'b001);
    rst = 1'b1;
    #1;
    check("arst_ack_r", ack_r0, 0);
    check("arst_occ", occ0, 0);
    check("arst_count", count0, 0);
    check("arst_req_l", req_l0, 0);
    check("arst_dout", dout0, 0);
    ch0.delete(); ch1.delete(); pend0.delete(); pend1.delete();
    repeat (2) @(negedge clk);
    req_r0 = 3'b111;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_req_l", req_l0, 2'b11);
    check("post_rst_count", count0, 0);
    pend0.push_back(32'd1); pend1.push_back(32'd2);
    drive(1'b0, 3'b111, 1'b1, 100);
    check("post_rst_val", log0.size() > 0 ? log0[0] : 32'hDEAD_BEEF, 32'd3);
    check("post_rst_count1", count0, 1);

    // Three-input subtract and multiply-by-immediate nodes, 8-bit wrap.
    run_u1(8'd5, 8'd7, 8'd1, 8'hFD);
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
    e8 = a - b - c;
    run_u1(a, b, c, e8);
    run_u2(8'd200, 8'h58);
    a = 8'($urandom);
    e8 = 8'((int'(a) * 3) % 256);
    run_u2(a, e8);
    check("u1_count", count1, 2);
    check("u2_count", count2, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/async_operator_buf.md
Name: async_operator_buf

Overview:
- Parametrised successor to the dataflow node operator.
- Collects one token from each of `input_size` upstream req/ack channels and applies the selected arithmetic op.
- Pushes the result into an internal result FIFO of `depth` entries.
- Delivers each result independently to `output_size` consumers, each with its own ack, so a slow consumer no longer blocks acknowledgement of the others.
- Sits between producers, consumers and other nodes inside the generated `arf` dataflow graphs; also replaces chains of pipeline `reg` nodes.

Parameters:
- data_width, 32, token width in bits
- op, "add", one of "reg","in","out","addi","subi","muli" (input_size=1) or "add","sub","mul" (input_size 2..3)
- immediate, 0, constant operand for addi/subi/muli
- input_size, 2, number of input channels, 1..3
- output_size, 1, number of output channels, 1..8
- depth, 4, result FIFO entries, power of two, >=2

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_l  out  input_size  per-input request to upstream
- ack_l  in  input_size  per-input 1-cycle ack from upstream; data valid same cycle
- din  in  data_width*input_size  input operands; slice i belongs to channel i
- req_r  in  output_size  per-output request from downstream
- ack_r  out  output_size  per-output 1-cycle ack to downstream
- dout  out  data_width  result, valid while any ack_r bit is high
- count  out  32  results pushed since reset
- occupancy  out  $clog2(depth)+1  FIFO entries currently held

Behaviour:
- Reset (async): has, req_l, ack_r, sent, dout, count, occupancy, FIFO pointers all go to 0. A token in flight is discarded; no ack_r pulse occurs after reset.
- Input side, per channel i, all registered on posedge clk:
  - req_l[i] <= 1 when has[i]=0 and ack_l[i]=0.
  - When ack_l[i]=1: latch din slice i, set has[i], req_l[i] <= 0.
  - req_l[i] stays 0 while has[i]=1.
  - A token is never accepted while has[i]=1; an ack_l[i] received while has[i]=1 is ignored.
- Compute/push:
  - At an edge where has is all-ones and occupancy < depth: push f(operands), increment count, clear all has bits.
  - Latency: ack_l edge -> has set; next edge -> push. Minimum 2 cycles from last ack_l to the result entering the FIFO.
  - Back-pressure: when the FIFO is full, has stays set and req_l stays low, so upstream stalls.
- Arithmetic, all modulo 2^data_width (truncated):
  - addi: d0+imm. subi: d0-imm. muli: d0*imm.
  - add: d0+d1(+d2). sub: d0-d1(-d2). mul: d0*d1(*d2).
  - d0 is the lowest slice of din. reg/in/out pass d0 through.
- Output side, per output j, acting on the FIFO head:
  - If occupancy>0, req_r[j]=1, sent[j]=0 and ack_r[j]=0: ack_r[j] <= 1 for exactly one cycle, sent[j] <= 1, and dout <= head.
  - Several outputs may be acked on the same edge.
- Pop:
  - On the edge where (sent | newly acked) becomes all-ones: pop the head and clear sent.
  - dout keeps the popped value until the next ack issue.
- Simultaneous push and pop at the same edge is legal when occupancy<depth before the edge; occupancy is then unchanged.
- Push when full is blocked even if a pop occurs that edge; the push takes effect one cycle later.
- No output ever receives two acks for the same entry. Entries leave in push order.
- occupancy never exceeds depth. The pointers wrap modulo depth.

Test Plan:
- op="add", input_size=2, output_size=1: tokens (3,4) then (10,20), consumer always requesting -> ack_r pulses with dout=7 then 30; count=2; occupancy returns to 0.
- op="sub", input_size=3: inputs d0=5, d1=7, d2=1, data_width=8 -> dout=8'hFD.
- output_size=3, depth=4: req_r[2] held low, 6 input tokens 1..6 -> outputs 0 and 1 each get ack for value 1 only; FIFO fills to occupancy=4; req_l stays 0 with has set. Release req_r[2] -> every output receives 1..6 in order, exactly once each.
- Push/pop same cycle at occupancy=2: occupancy stays 2, no entry lost or duplicated.
- Async reset asserted mid-stream with occupancy=3 and one ack_r high: all outputs 0 immediately, without waiting for clk. After release, req_l rises on the first edge and count restarts at 0.
- op="muli", immediate=3, input_size=1, data_width=8, input 200 -> dout=8'h58 (600 mod 256).
